// File: rtl/ul_seq.sv
// ul_seq: bit-serial two-operand logic unit (AND/OR/XOR/NOT-A), one result bit per clock, LSB first.
// Latency: done is high W+1 edges after the start-accept edge (counting that edge); back-to-back period W+2.
// Backpressure: none; start is only honoured in IDLE and ignored while busy. Optional zero flag: `define UL_SEQ_ZFLAG_EN.
module ul_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   s,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out
`ifdef UL_SEQ_ZFLAG_EN
  ,
  output logic         zero
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [1:0]     s_r;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   sr;
  logic           res_bit;
  logic [W-1:0]   res_full;
  logic           last_bit;
  logic           sr_lsb_unused;

  // Single 1-bit logic cell applied to the latched operand bit selected by cnt.
  always_comb begin
    res_bit = 1'b0;
    case (s_r)
      2'b00:   res_bit = a_r[cnt] & b_r[cnt];
      2'b01:   res_bit = a_r[cnt] | b_r[cnt];
      2'b10:   res_bit = a_r[cnt] ^ b_r[cnt];
      2'b11:   res_bit = ~a_r[cnt];
      default: res_bit = 1'b0;
    endcase
  end

  // New bit enters at the MSB; after W shifts bit 0 of the result sits at the LSB.
  assign res_full = {res_bit, sr[W-1:1]};
  assign last_bit = (state == RUN) && (cnt == LAST);
  // The shift register's LSB only fills on the final shift, which goes straight into out.
  assign sr_lsb_unused = sr[0];

  // Control FSM with registered busy/done/out; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      out   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            s_r   <= s;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sr <= res_full;
          if (cnt == LAST) begin
            // Counter parks at W-1 rather than wrapping; it is cleared on the next accept.
            out   <= res_full;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UL_SEQ_ZFLAG_EN
  // Zero flag is captured together with out on DONE entry and held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero <= 1'b0;
    end else if (last_bit) begin
      zero <= (res_full == '0);
    end
  end
`endif

endmodule
